// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path constants and the fetch-entry record
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: DEPTH-entry fetch-entry FIFO with same-cycle push/pop and flush
module pf_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [2*XLEN-1:0]          wdata_i,
  output logic [2*XLEN-1:0]          head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  always_comb begin
    do_push = push_i && !flush_i;
    do_pop = pop_i && !flush_i && count_q != '0;
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      count_q <= (do_push && !do_pop) ? count_q + CW'(1) :
                 (do_pop && !do_push) ? count_q - CW'(1) : count_q;
    end
  end
  // credit accounting upstream must make a push into a full queue impossible
  always_ff @(posedge clk) begin
    if (!rst) assert (!(do_push && count_q == CW'(DEPTH)));
  end
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: in-order instruction prefetcher feeding IF_ID with a
// credit-limited imem request stream, a flushable FIFO and stale-response drop
module if_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUT   = 2,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        condn_flag,
  input  logic [31:0] adder,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        pf_valid,
  output logic [31:0] pf_ir,
  output logic [31:0] pf_npc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  fetch_entry_t head, wentry;
  logic [CW-1:0] count;
  logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, addr_q, target;
  logic [OW-1:0] inflight_q, inflight_d, drop_q, drop_d;
  logic req_q, issue, rsp, keep, pop;
  always_comb begin
    target = word_align(adder);
    rsp = imem_rvalid && inflight_q != '0;
    keep = rsp && drop_q == '0 && !condn_flag;
    pop = count != '0 && !stall && !condn_flag;
    // credit counts queued entries plus every non-stale request still owed
    issue = !rst && !condn_flag && int'(inflight_q) < MAX_OUT &&
            int'(count) + int'(inflight_q) - int'(drop_q) < DEPTH;
    pc_d = condn_flag ? target : issue ? pc_q + 32'd4 : pc_q;
    resp_pc_d = condn_flag ? target : keep ? resp_pc_q + 32'd4 : resp_pc_q;
    inflight_d = inflight_q + OW'(issue) - OW'(rsp);
    drop_d = condn_flag ? inflight_q - OW'(rsp) :
             (rsp && drop_q != '0) ? drop_q - OW'(1) : drop_q;
    wentry = '{ir: imem_rdata, pc: resp_pc_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q <= '0;
      req_q <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      resp_pc_q <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
      req_q <= issue;
      addr_q <= issue ? pc_q : addr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (drop_q <= inflight_q);
  end
  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (condn_flag),
    .push_i  (keep),
    .pop_i   (pop),
    .wdata_i (wentry),
    .head_o  (head),
    .count_o (count)
  );
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign pf_valid = count != '0;
  assign pf_ir = pf_valid ? head.ir : NOP_INSTR;
  assign pf_npc = pf_valid ? head.pc + 32'd4 : 32'd0;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: random + directed bench; a program-order scoreboard
// predicts every delivered IR/NPC pair and every fetch address
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 1, stall = 0, condn_flag = 0;
  logic [31:0] adder = 0;
  logic imem_req, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic pf_valid;
  logic [31:0] pf_ir, pf_npc;
  int total = 0, bad = 0, cyc = 0, reqs = 0, pops = 0, epoch = 0;
  int lat_min = 1, lat_max = 1, gate = 0;
  typedef struct {
    logic [31:0] addr;
    int ready;
    int ep;
  } req_t;
  req_t pend[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch = RPC, exp_resp = RPC;

  if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .condn_flag(condn_flag), .adder(adder),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pf_valid(pf_valid), .pf_ir(pf_ir), .pf_npc(pf_npc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step(2);
    rst = 0;
  endtask

  task automatic wait_pf(input string name);
    int n = 0;
    while (!pf_valid && n < 30) begin
      step(1);
      n++;
    end
    if (!pf_valid) begin
      total++;
      bad++;
      $display("FAIL %s: pf_valid still 0 after %0d cycles", name, n);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 30) begin
      step(1);
      n++;
    end
    if (!imem_req) begin
      total++;
      bad++;
      $display("FAIL %s: imem_req still 0 after %0d cycles", name, n);
    end
  endtask

  // memory model and scoreboard, evaluated mid-cycle
  always @(negedge clk) begin : mon
    req_t r;
    logic [63:0] e;
    cyc++;
    if (!rst) begin
      if (pf_valid && !stall && !condn_flag) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got ir=%h npc=%h with nothing expected", pf_ir, pf_npc);
        end else begin
          e = exp_q.pop_front();
          chk("pop_ir", pf_ir, e[63:32]);
          chk("pop_npc", pf_npc, e[31:0]);
        end
      end else if (!pf_valid) begin
        chk("empty_ir", pf_ir, NOP);
        chk("empty_npc", pf_npc, 32'h0);
      end
    end
    if (imem_req === 1'b1) begin
      reqs++;
      chk("fetch_addr", imem_addr, exp_fetch);
      exp_fetch += 32'd4;
      pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min)), epoch});
      chk("outstanding_ok", 32'(pend.size() <= MAX_OUT), 32'd1);
    end
    imem_rvalid = 0;
    imem_rdata = $urandom;
    if (pend.size() > 0 && pend[0].ready <= cyc && (gate == 0 || $urandom_range(0, 3) != 0)) begin
      r = pend.pop_front();
      imem_rvalid = 1;
      imem_rdata = mem_f(r.addr);
      if (r.ep == epoch && !condn_flag && !rst) begin
        exp_q.push_back({mem_f(exp_resp), exp_resp + 32'd4});
        exp_resp += 32'd4;
      end
    end
    if (rst) begin
      pend.delete();
      exp_q.delete();
      exp_fetch = RPC;
      exp_resp = RPC;
      epoch++;
    end else if (condn_flag) begin
      exp_q.delete();
      exp_fetch = {adder[31:2], 2'b00};
      exp_resp = exp_fetch;
      epoch++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, n;
    rst = 1;
    step(2);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(pf_valid), 32'd0);
    chk("rst_ir", pf_ir, NOP);
    chk("rst_npc", pf_npc, 32'h0);
    // 1: single-cycle memory, free-running stream
    rst = 0;
    step(1);
    chk("t1_first_req", 32'(imem_req), 32'd1);
    chk("t1_first_addr", imem_addr, RPC);
    wait_pf("t1_wait");
    chk("t1_first_ir", pf_ir, 32'h00A0_0093);
    chk("t1_first_npc", pf_npc, 32'h4);
    step(10);
    // 2: stalled decode fills exactly DEPTH entries
    stall = 1;
    do_reset();
    r0 = reqs;
    step(12);
    chk("t2_reqs", 32'(reqs - r0), 32'(DEPTH));
    chk("t2_req_idle", 32'(imem_req), 32'd0);
    chk("t2_head_ir", pf_ir, mem_f(32'h0));
    chk("t2_head_npc", pf_npc, 32'h4);
    stall = 0;
    step(10);
    // 3: redirect with two stale requests outstanding
    lat_min = 3;
    lat_max = 3;
    do_reset();
    step(6);
    n = 0;
    while (pend.size() < 2 && n < 10) begin
      step(1);
      n++;
    end
    adder = 32'h0000_0102;
    condn_flag = 1;
    step(1);
    condn_flag = 0;
    wait_req("t3_req");
    chk("t3_addr", imem_addr, 32'h0000_0100);
    wait_pf("t3_wait");
    chk("t3_ir", pf_ir, mem_f(32'h100));
    chk("t3_npc", pf_npc, 32'h104);
    step(8);
    // 4: redirect coinciding with a response and a pop
    lat_min = 1;
    lat_max = 1;
    do_reset();
    step(6);
    n = 0;
    while (!(pf_valid && pend.size() > 0) && n < 20) begin
      step(1);
      n++;
    end
    adder = 32'h0000_0200;
    condn_flag = 1;
    step(1);
    condn_flag = 0;
    chk("t4_flushed", 32'(pf_valid), 32'd0);
    wait_pf("t4_wait");
    chk("t4_ir", pf_ir, mem_f(32'h200));
    chk("t4_npc", pf_npc, 32'h204);
    step(6);
    // 5: reset mid-stream
    stall = 1;
    lat_min = 3;
    lat_max = 3;
    do_reset();
    step(6);
    rst = 1;
    step(1);
    chk("t5_valid", 32'(pf_valid), 32'd0);
    chk("t5_ir", pf_ir, NOP);
    chk("t5_req", 32'(imem_req), 32'd0);
    rst = 0;
    step(1);
    chk("t5_req_after", 32'(imem_req), 32'd1);
    chk("t5_addr_after", imem_addr, RPC);
    stall = 0;
    step(10);
    // 6: pc wrap
    stall = 1;
    lat_min = 2;
    lat_max = 2;
    adder = 32'hFFFF_FFFC;
    condn_flag = 1;
    step(1);
    condn_flag = 0;
    wait_pf("t6_wait");
    chk("t6_ir", pf_ir, mem_f(32'hFFFF_FFFC));
    chk("t6_npc", pf_npc, 32'h0);
    stall = 0;
    step(10);
    // random traffic
    gate = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        lat_min = 1;
        lat_max = int'($urandom_range(1, 5));
      end
      stall = $urandom_range(0, 9) < 3;
      condn_flag = $urandom_range(0, 49) == 0;
      adder = $urandom;
      rst = $urandom_range(0, 299) == 0;
      step(1);
    end
    rst = 0;
    condn_flag = 0;
    stall = 0;
    step(5);
    chk("liveness", 32'(pops > 500), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
